// File: rtl/bitty_exec_sequencer.sv
// Fetch/issue/retire controller for the bitty core: runs one instruction at a
// time through memory read, core run pulse, completion wait and PC update.
module bitty_exec_sequencer #(
    parameter int ADDR_W  = 8,
    parameter int MEM_LAT = 1,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              step,
    input  logic              halt_req,
    input  logic              bp_en,
    input  logic [ADDR_W-1:0] bp_addr,
    input  logic [ADDR_W-1:0] pc_addr,
    input  logic              core_done,
    output logic              mem_rd_en,
    output logic              core_run,
    output logic              pc_en,
    output logic              busy,
    output logic              halted,
    output logic              bp_hit,
    output logic              err,
    output logic [CNT_W-1:0]  instr_count,
    output logic [3:0]        state_o
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_WAIT_MEM = 4'd2,
        S_ISSUE    = 4'd3,
        S_EXEC     = 4'd4,
        S_UPDATE   = 4'd5,
        S_CHECK    = 4'd6,
        S_HALTED   = 4'd7,
        S_ERROR    = 4'd8
    } state_t;

    // Watchdog counts EXEC cycles; the last legal value is TIMEOUT-2, so the
    // ERROR state is reached TIMEOUT-1 cycles after entering EXEC.
    localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 2);
    localparam int ML_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [ML_W-1:0] ML_LAST = ML_W'((MEM_LAT > 0) ? MEM_LAT - 1 : 0);

    state_t            state_q, state_d;
    logic              step_mode_q, step_mode_d;
    logic              halt_pend_q, halt_pend_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [ML_W-1:0]   mc_q, mc_d;
    logic              bp_hit_q, bp_hit_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_w;

    assign busy_w = (state_q == S_FETCH) || (state_q == S_WAIT_MEM) ||
                    (state_q == S_ISSUE) || (state_q == S_EXEC) ||
                    (state_q == S_UPDATE) || (state_q == S_CHECK);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            step_mode_q <= 1'b0;
            halt_pend_q <= 1'b0;
            wd_q        <= '0;
            mc_q        <= '0;
            bp_hit_q    <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            step_mode_q <= step_mode_d;
            halt_pend_q <= halt_pend_d;
            wd_q        <= wd_d;
            mc_q        <= mc_d;
            bp_hit_q    <= bp_hit_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        step_mode_d = step_mode_q;
        halt_pend_d = halt_pend_q;
        wd_d        = wd_q;
        mc_d        = mc_q;
        bp_hit_d    = bp_hit_q;
        err_d       = err_q;
        cnt_d       = cnt_q;

        if (busy_w && halt_req) halt_pend_d = 1'b1;

        case (state_q)
            S_IDLE, S_HALTED: begin
                if (step || start) begin
                    state_d     = S_FETCH;
                    step_mode_d = step;
                    bp_hit_d    = 1'b0;
                end
            end
            S_FETCH: begin
                mc_d    = '0;
                state_d = (MEM_LAT > 0) ? S_WAIT_MEM : S_ISSUE;
            end
            S_WAIT_MEM: begin
                if (mc_q == ML_LAST) state_d = S_ISSUE;
                else                 mc_d = mc_q + 1'b1;
            end
            S_ISSUE: begin
                wd_d    = '0;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                // A completion landing on the timeout cycle still retires.
                if (core_done) begin
                    state_d = S_UPDATE;
                end else if (wd_q == WD_LAST) begin
                    state_d = S_ERROR;
                    err_d   = 1'b1;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_UPDATE: begin
                if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (step_mode_q) begin
                    state_d = S_IDLE;
                end else if (halt_pend_q) begin
                    state_d = S_HALTED;
                end else if (bp_en && (pc_addr == bp_addr)) begin
                    state_d  = S_HALTED;
                    bp_hit_d = 1'b1;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_IDLE;
        endcase

        if ((state_d == S_IDLE) || (state_d == S_HALTED)) halt_pend_d = 1'b0;
    end

    assign mem_rd_en   = (state_q == S_FETCH);
    assign core_run    = (state_q == S_ISSUE);
    assign pc_en       = (state_q == S_UPDATE);
    assign busy        = busy_w;
    assign halted      = (state_q == S_HALTED);
    assign bp_hit      = bp_hit_q;
    assign err         = err_q;
    assign instr_count = cnt_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_bitty_exec_sequencer.sv
// Bench for bitty_exec_sequencer: directed scenarios plus random control traffic,
// every cycle checked against a behavioural model through an expected queue.
module tb_bitty_exec_sequencer;

    localparam int ADDR_W  = 8;
    localparam int MEM_LAT = 1;
    localparam int TIMEOUT = 64;
    localparam int CNT_W   = 16;
    localparam int W       = 4 + 7 + CNT_W;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset, start, step, halt_req, bp_en;
    logic [ADDR_W-1:0] bp_addr;
    logic [ADDR_W-1:0] pc_reg;
    logic              pc_clr;
    logic              core_done = 1'b0;
    logic              mem_rd_en, core_run, pc_en, busy, halted, bp_hit, err;
    logic [CNT_W-1:0]  instr_count;
    logic [3:0]        state_o;

    bitty_exec_sequencer #(
        .ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .step(step),
        .halt_req(halt_req), .bp_en(bp_en), .bp_addr(bp_addr),
        .pc_addr(pc_reg), .core_done(core_done),
        .mem_rd_en(mem_rd_en), .core_run(core_run), .pc_en(pc_en),
        .busy(busy), .halted(halted), .bp_hit(bp_hit), .err(err),
        .instr_count(instr_count), .state_o(state_o)
    );

    // Second build: no memory wait, short watchdog, 2-bit retire counter.
    logic       step0, cd0;
    logic       mr0, cr0, pe0, bz0, hl0, bh0, er0;
    logic [1:0] cnt0;
    logic [3:0] st0;

    bitty_exec_sequencer #(
        .ADDR_W(8), .MEM_LAT(0), .TIMEOUT(4), .CNT_W(2)
    ) dut0 (
        .clk(clk), .reset(reset), .start(1'b0), .step(step0),
        .halt_req(1'b0), .bp_en(1'b0), .bp_addr(8'd0),
        .pc_addr(8'd0), .core_done(cd0),
        .mem_rd_en(mr0), .core_run(cr0), .pc_en(pe0),
        .busy(bz0), .halted(hl0), .bp_hit(bh0), .err(er0),
        .instr_count(cnt0), .state_o(st0)
    );

    // PC register that the sequencer steps through pc_en.
    always @(posedge clk) begin
        if (pc_clr)     pc_reg <= '0;
        else if (pc_en) pc_reg <= pc_reg + 8'd1;
    end

    // ---------------- core responder ----------------
    int core_mode = 0;   // 0: never done, 1: done after delay from core_run, 2: random
    int fixed_dly = 0;
    int dly       = 0;
    always @(negedge clk) begin
        core_done = 1'b0;
        case (core_mode)
            1: begin
                if (core_run) begin
                    dly = (fixed_dly > 0) ? fixed_dly : int'($urandom_range(1, 4));
                end else if (dly > 0) begin
                    dly--;
                    core_done = (dly == 0);
                end
            end
            2: core_done = ($urandom_range(0, 2) == 0);
            default: dly = 0;
        endcase
    end

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_bad = 0;
    logic [W-1:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Behavioural model: expected state code, retire count and flags.
    int m_st = 0, m_mem_left = 0, m_exec_cyc = 0, m_cnt = 0;
    bit m_step_mode = 0, m_pend = 0, m_bp = 0, m_err = 0;

    task automatic model_step();
        bit nxt_pend;
        if (reset) begin
            m_st = 0; m_cnt = 0; m_pend = 0; m_bp = 0; m_err = 0; m_step_mode = 0;
            return;
        end
        nxt_pend = m_pend || ((m_st >= 1) && (m_st <= 6) && halt_req);
        case (m_st)
            0, 7: if (step || start) begin m_step_mode = step; m_bp = 0; m_st = 1; end
            1: begin m_mem_left = MEM_LAT; m_st = (MEM_LAT == 0) ? 3 : 2; end
            2: begin m_mem_left--; if (m_mem_left == 0) m_st = 3; end
            3: begin m_exec_cyc = 0; m_st = 4; end
            4: begin
                m_exec_cyc++;
                if (core_done) m_st = 5;
                else if (m_exec_cyc == TIMEOUT - 1) begin m_st = 8; m_err = 1; end
            end
            5: begin if (m_cnt < (1 << CNT_W) - 1) m_cnt++; m_st = 6; end
            6: begin
                if (m_step_mode) m_st = 0;
                else if (m_pend) m_st = 7;
                else if (bp_en && (pc_reg == bp_addr)) begin m_st = 7; m_bp = 1; end
                else m_st = 1;
            end
            default: ;
        endcase
        if ((m_st == 0) || (m_st == 7)) nxt_pend = 0;
        m_pend = nxt_pend;
    endtask

    function automatic logic [W-1:0] model_vec();
        return {4'(m_st), m_st == 1, m_st == 3, m_st == 5, (m_st >= 1) && (m_st <= 6),
                m_st == 7, m_bp, m_err, CNT_W'(m_cnt)};
    endfunction

    always @(posedge clk) begin
        model_step();
        exp_q.push_back(model_vec());
    end

    // One compare per cycle, mid-period.
    always @(negedge clk) begin
        logic [W-1:0] e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {state_o, mem_rd_en, core_run, pc_en, busy, halted, bp_hit, err, instr_count};
            n_vec++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL cycle_vec: got %h, expected %h (state %0d vs %0d, t=%0t)",
                         a, e, a[W-1 -: 4], e[W-1 -: 4], $time);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; pc_clr = 1'b1;
        tick(); tick();
        reset = 1'b0; pc_clr = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic wait_st(input logic [3:0] code, input int budget, input string what);
        int n = 0;
        while ((state_o !== code) && (n < budget)) begin tick(); n++; end
        chk(what, 32'(state_o), 32'(code));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        reset = 1'b1; pc_clr = 1'b1; start = 1'b0; step = 1'b0; halt_req = 1'b0;
        bp_en = 1'b0; bp_addr = '0; step0 = 1'b0; cd0 = 1'b0;
        do_reset();

        // Reset state and single-step timing.
        chk("rst state", 32'(state_o), 32'd0);
        chk("rst count", 32'(instr_count), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        core_mode = 1; fixed_dly = 2;
        step = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick(); step = 1'b0;
            chk($sformatf("t1 mem_rd_en c%0d", k), 32'(mem_rd_en), 32'(k == 1));
            chk($sformatf("t1 core_run c%0d", k), 32'(core_run), 32'(k == 3));
            chk($sformatf("t1 pc_en c%0d", k), 32'(pc_en), 32'(k == 6));
            chk($sformatf("t1 busy c%0d", k), 32'(busy), 32'((k >= 1) && (k <= 7)));
        end
        chk("t1 idle", 32'(state_o), 32'd0);
        chk("t1 count", 32'(instr_count), 32'd1);
        fixed_dly = 0;

        // MEM_LAT=0 build: ISSUE right after FETCH, saturation, short watchdog.
        cd0 = 1'b1; step0 = 1'b1; tick(); step0 = 1'b0;
        chk("m0 fetch", 32'(st0), 32'd1);
        tick(); chk("m0 issue", 32'(st0), 32'd3);
        tick(); chk("m0 exec", 32'(st0), 32'd4);
        tick(); chk("m0 update", 32'(st0), 32'd5);
        tick(); chk("m0 check", 32'(st0), 32'd6);
        tick(); chk("m0 idle", 32'(st0), 32'd0);
        chk("m0 count", 32'(cnt0), 32'd1);
        repeat (4) begin step0 = 1'b1; tick(); step0 = 1'b0; repeat (6) tick(); end
        chk("m0 saturate", 32'(cnt0), 32'd3);
        cd0 = 1'b0; step0 = 1'b1; tick(); step0 = 1'b0; tick(); tick();
        chk("m0 exec2", 32'(st0), 32'd4);
        n = 0;
        while ((st0 == 4'd4) && (n < 50)) begin tick(); n++; end
        chk("m0 timeout cycles", 32'(n), 32'd3);
        chk("m0 err", 32'(er0), 32'd1);

        // Breakpoint at 5, then resume past it.
        do_reset();
        bp_en = 1'b1; bp_addr = 8'd5;
        pulse_start();
        wait_st(4'd7, 200, "t2 halted state");
        chk("t2 halted", 32'(halted), 32'd1);
        chk("t2 bp_hit", 32'(bp_hit), 32'd1);
        chk("t2 pc", 32'(pc_reg), 32'd5);
        chk("t2 count", 32'(instr_count), 32'd5);
        pulse_start();
        chk("t2 bp_hit cleared", 32'(bp_hit), 32'd0);
        n = 0;
        while ((pc_reg != 8'd8) && (n < 200)) begin tick(); n++; end
        chk("t2 ran past bp", 32'(pc_reg), 32'd8);
        chk("t2 not halted", 32'(halted), 32'd0);

        // halt_req during EXEC of the third instruction.
        do_reset();
        bp_en = 1'b0;
        pulse_start();
        n = 0;
        while (!((instr_count == 16'd2) && (state_o == 4'd4)) && (n < 200)) begin tick(); n++; end
        chk("t3 third exec", 32'(state_o), 32'd4);
        halt_req = 1'b1; tick(); halt_req = 1'b0;
        wait_st(4'd7, 100, "t3 halted state");
        chk("t3 count", 32'(instr_count), 32'd3);
        chk("t3 pc", 32'(pc_reg), 32'd3);
        chk("t3 bp_hit", 32'(bp_hit), 32'd0);

        // Watchdog: no core_done.
        do_reset();
        core_mode = 0;
        pulse_start();
        wait_st(4'd4, 20, "t4 exec entry");
        n = 0;
        while ((state_o == 4'd4) && (n < 200)) begin tick(); n++; end
        chk("t4 exec cycles", 32'(n), 32'd63);
        chk("t4 error state", 32'(state_o), 32'd8);
        chk("t4 err", 32'(err), 32'd1);
        start = 1'b1; repeat (3) tick(); start = 1'b0;
        chk("t4 start ignored", 32'(state_o), 32'd8);
        chk("t4 no pc_en", 32'(pc_reg), 32'd0);
        do_reset();
        chk("t4 reset idle", 32'(state_o), 32'd0);
        chk("t4 reset err", 32'(err), 32'd0);

        // start and step together: one instruction only.
        core_mode = 1;
        start = 1'b1; step = 1'b1; tick(); start = 1'b0; step = 1'b0;
        wait_st(4'd0, 50, "t5 back to idle");
        chk("t5 count", 32'(instr_count), 32'd1);
        repeat (3) tick();
        chk("t5 stays idle", 32'(state_o), 32'd0);

        // Reset while waiting on memory.
        step = 1'b1; tick(); step = 1'b0;
        tick();
        chk("t6 wait_mem", 32'(state_o), 32'd2);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("t6 idle", 32'(state_o), 32'd0);
        chk("t6 count", 32'(instr_count), 32'd0);
        chk("t6 core_run", 32'(core_run), 32'd0);
        chk("t6 busy", 32'(busy), 32'd0);

        // Random control traffic.
        core_mode = 2;
        for (int i = 0; i < 3000; i++) begin
            reset    = ($urandom_range(0, 399) == 0);
            pc_clr   = reset;
            start    = ($urandom_range(0, 14) == 0);
            step     = ($urandom_range(0, 24) == 0);
            halt_req = ($urandom_range(0, 19) == 0);
            bp_en    = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 49) == 0) bp_addr = 8'($urandom_range(0, 15));
            if ($urandom_range(0, 199) == 0) core_mode = int'($urandom_range(1, 2));
            tick();
        end
        reset = 1'b0; pc_clr = 1'b0; start = 1'b0; step = 1'b0; halt_req = 1'b0;
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
